switches_logic_core: RTL and testbench

Board-level front end that turns four raw mechanical switch inputs into four LED drive signals. Each switch is synchronised into the single clock domain, optionally debounced, and then combined by fixed Boolean functions. The outputs are registered. The block sits between the top-level pads and the LED pins.

---
 rtl/switches_logic_pkg.sv | 18 +
 rtl/switches_logic_core_debouncer.sv | 56 +++++
 rtl/switches_logic_core.sv | 53 +++++
 tb/tb_switches_logic_core.sv | 172 +++++++++++++++++
 4 files changed

// File: rtl/switches_logic_pkg.sv
// rtl/switches_logic_pkg.sv - shared constants and the switch-to-LED Boolean map
package switches_logic_pkg;

  localparam int NUM_SWITCHES = 4;

  // Bit n of the argument is switch n+1; bit n of the result is LED n+1.
  function automatic logic [NUM_SWITCHES-1:0] led_from_state(
    input logic [NUM_SWITCHES-1:0] i_state
  );
    logic [NUM_SWITCHES-1:0] w_led;
    w_led[0] = i_state[0] & i_state[1];
    w_led[1] = i_state[0] | i_state[1];
    w_led[2] = i_state[2] ^ i_state[3];
    w_led[3] = ~(i_state[2] | i_state[3]);
    return w_led;
  endfunction

endpackage

// File: rtl/switches_logic_core_debouncer.sv
// rtl/switches_logic_core_debouncer.sv - per-switch sync chain and optional debounce (SWITCHES_LOGIC_DEBOUNCE_EN)
module switch_debouncer #(
  parameter int unsigned DEBOUNCE_CYCLES = 16
) (
  input  logic i_clk,
  input  logic i_rst_n,
  input  logic i_raw,
  output logic o_level
);

  logic r_sync1;
  logic r_sync2;

  // Two-flop synchroniser for the asynchronous switch input
  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      r_sync1 <= 1'b0;
      r_sync2 <= 1'b0;
    end else begin
      r_sync1 <= i_raw;
      r_sync2 <= r_sync1;
    end
  end

`ifdef SWITCHES_LOGIC_DEBOUNCE_EN
  localparam int CW = $clog2(DEBOUNCE_CYCLES + 1);
  localparam logic [CW-1:0] LAST_COUNT = CW'(DEBOUNCE_CYCLES - 1);

  logic          r_state;
  logic [CW-1:0] r_count;

  // Accept a new level only after DEBOUNCE_CYCLES consecutive differing samples;
  // any sample agreeing with the accepted level throws the partial count away.
  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      r_state <= 1'b0;
      r_count <= '0;
    end else if (r_sync2 == r_state) begin
      r_count <= '0;
    end else if (r_count == LAST_COUNT) begin
      r_state <= r_sync2;
      r_count <= '0;
    end else begin
      r_count <= r_count + CW'(1);
    end
  end

  assign o_level = r_state;
`else
  // Without debounce the accepted level is the second sync flop itself.
  localparam logic [15:0] unused_debounce_cycles = 16'(DEBOUNCE_CYCLES);

  assign o_level = r_sync2;
`endif

endmodule

// File: rtl/switches_logic_core.sv
// rtl/switches_logic_core.sv - four filtered switches driving four registered LEDs (SWITCHES_LOGIC_DEBOUNCE_EN)
module switches_logic_core
  import switches_logic_pkg::*;
#(
  parameter int unsigned DEBOUNCE_CYCLES = 16
) (
  input  logic i_clk,
  input  logic i_rst_n,
  input  logic i_switch_1,
  input  logic i_switch_2,
  input  logic i_switch_3,
  input  logic i_switch_4,
  output logic o_led_1,
  output logic o_led_2,
  output logic o_led_3,
  output logic o_led_4
);

  logic [NUM_SWITCHES-1:0] w_raw;
  logic [NUM_SWITCHES-1:0] w_level;
  logic [NUM_SWITCHES-1:0] r_led;

  assign w_raw = {i_switch_4, i_switch_3, i_switch_2, i_switch_1};

  genvar g;
  generate
    for (g = 0; g < NUM_SWITCHES; g++) begin : g_sw
      switch_debouncer #(
        .DEBOUNCE_CYCLES(DEBOUNCE_CYCLES)
      ) u_deb (
        .i_clk   (i_clk),
        .i_rst_n (i_rst_n),
        .i_raw   (w_raw[g]),
        .o_level (w_level[g])
      );
    end
  endgenerate

  // LED register reloads every cycle from the current filtered levels
  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      r_led <= '0;
    end else begin
      r_led <= led_from_state(w_level);
    end
  end

  assign o_led_1 = r_led[0];
  assign o_led_2 = r_led[1];
  assign o_led_3 = r_led[2];
  assign o_led_4 = r_led[3];

endmodule

// File: tb/tb_switches_logic_core.sv
// tb/tb_switches_logic_core.sv - randomized and directed checks against a sample-window model
module tb_switches_logic_core;

  localparam int DB = 4;
`ifdef SWITCHES_LOGIC_DEBOUNCE_EN
  localparam int LAT = 3 + DB;
`else
  localparam int LAT = 3;
`endif

  logic clk = 1'b0;
  logic rst_n;
  logic [3:0] sw;
  logic led1, led2, led3, led4;
  logic [3:0] led;

  int checks = 0;
  int errors = 0;

  logic [3:0] m_sync1, m_sync2, m_state, m_led;
  logic [3:0] hist[$];

  switches_logic_core #(.DEBOUNCE_CYCLES(DB)) dut (
    .i_clk      (clk),
    .i_rst_n    (rst_n),
    .i_switch_1 (sw[0]),
    .i_switch_2 (sw[1]),
    .i_switch_3 (sw[2]),
    .i_switch_4 (sw[3]),
    .o_led_1    (led1),
    .o_led_2    (led2),
    .o_led_3    (led3),
    .o_led_4    (led4)
  );

  assign led = {led4, led3, led2, led1};

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h at %0t", tag, got, exp, $time);
    end
  endtask

  // LED vector straight from the Boolean definitions (bit n = LED n+1)
  function automatic logic [3:0] ref_led(input logic [3:0] s);
    logic a, b, c, d;
    a = s[0]; b = s[1]; c = s[2]; d = s[3];
    return {!(c || d), c != d, a || b, a && b};
  endfunction

  task automatic model_reset();
    m_sync1 = '0;
    m_sync2 = '0;
    m_state = '0;
    m_led   = '0;
    hist.delete();
  endtask

  // One rising edge: a level is accepted once the last DB synchronised samples
  // all agree and differ from the accepted level.
  task automatic model_update(input logic [3:0] raw);
    logic [3:0] s2b;
    s2b = m_sync2;
`ifdef SWITCHES_LOGIC_DEBOUNCE_EN
    m_led = ref_led(m_state);
    hist.push_back(s2b);
    if (hist.size() > DB) void'(hist.pop_front());
    if (hist.size() == DB) begin
      for (int i = 0; i < 4; i++) begin
        bit agree;
        agree = 1'b1;
        for (int j = 1; j < DB; j++) if (hist[j][i] != hist[0][i]) agree = 1'b0;
        if (agree && hist[0][i] != m_state[i]) m_state[i] = hist[0][i];
      end
    end
`else
    m_led = ref_led(s2b);
`endif
    m_sync2 = m_sync1;
    m_sync1 = raw;
  endtask

  task automatic step(input logic [3:0] s, input logic r);
    @(negedge clk);
    sw = s;
    rst_n = r;
    @(posedge clk);
    if (!r) model_reset();
    else model_update(s);
    #1;
    check("led_vs_model", {28'd0, led}, {28'd0, m_led});
  endtask

  initial begin
    logic [3:0] cur;
    int hold;

    // 1: reset with switches low
    rst_n = 1'b0;
    sw = '0;
    model_reset();
    #1;
    check("reset_leds", {28'd0, led}, 32'h0);
    for (int i = 0; i < 3; i++) step(4'b0000, 1'b0);
    step(4'b0000, 1'b1);
    check("first_edge_after_release", {28'd0, led}, 32'b1000);

    // 2: switches 1,1,0,0 held stable
    for (int e = 1; e <= LAT + 1; e++) begin
      step(4'b0011, 1'b1);
      if (e == LAT - 1) check("s2_before_latency", {28'd0, led}, 32'b1000);
      if (e == LAT) check("s2_at_latency", {28'd0, led}, 32'b1011);
    end

    // 3: two more stable patterns
    for (int e = 0; e < 10; e++) step(4'b0110, 1'b1);
    check("s3_pattern_0110", {28'd0, led}, 32'b0110);
    for (int e = 0; e < 10; e++) step(4'b1100, 1'b1);
    check("s3_pattern_0011", {28'd0, led}, 32'b0000);

    // 4/6: glitch on switch 3
    for (int e = 0; e < 10; e++) step(4'b0000, 1'b1);
`ifdef SWITCHES_LOGIC_DEBOUNCE_EN
    for (int e = 0; e < 11; e++) begin
      step(e < 3 ? 4'b0100 : 4'b0000, 1'b1);
      check("glitch_led3_low", {31'd0, led3}, 32'd0);
      check("glitch_led4_high", {31'd0, led4}, 32'd1);
    end
`else
    for (int e = 1; e <= 5; e++) begin
      step(e == 1 ? 4'b0100 : 4'b0000, 1'b1);
      if (e == 3) check("glitch_passes_led3", {31'd0, led3}, 32'd1);
      if (e == 4) check("glitch_gone_led3", {31'd0, led3}, 32'd0);
    end
`endif

    // 5: reset in the middle of a count
    for (int e = 0; e < 4; e++) step(4'b0001, 1'b1);
    @(posedge clk);
    #2;
    rst_n = 1'b0;
    #1;
    check("async_reset_leds", {28'd0, led}, 32'h0);
    model_reset();
    step(4'b0001, 1'b0);
    for (int e = 1; e <= LAT + 1; e++) begin
      step(4'b0001, 1'b1);
      if (e == LAT - 1) check("restart_led2_low", {31'd0, led2}, 32'd0);
      if (e == LAT) check("restart_led2_high", {31'd0, led2}, 32'd1);
    end

    // random switch activity with mixed glitch and stable hold lengths
    cur = '0;
    hold = 1;
    for (int c = 0; c < 400; c++) begin
      if (hold == 0) begin
        cur = 4'($urandom);
        hold = $urandom_range(1, 8);
      end
      hold--;
      step(cur, 1'b1);
    end

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
